// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage of the MIPS pipeline. It owns a byte-loadable word
// instruction memory, a byte-to-word program loader and the PC controller
// (IDLE / RUN / HALTED). It sits between the debug/UART program loader and
// the IF/ID pipeline register.
//
// A PC issued at one edge is looked up combinationally and the word is
// registered at the next edge, together with its PC and a valid flag.
// Fetching a HALT_WORD parks the controller in HALTED with a sticky o_is_end.
//
// Optional feature macro: IF_DEBUG_STEP_EN
//   defined   : in RUN a fetch advances only on edges with i_step=1 and
//               i_stall=0; every other RUN cycle behaves as a stall.
//   undefined : i_step is ignored.
//
// Ports
//   i_clock                      rising-edge clock
//   i_reset                      async active-high reset, clears memory too
//   i_pc_reset                   sync return to IDLE, memory retained
//   i_start                      IDLE -> RUN
//   i_load_program_byte          loader byte, first byte is the word MSB
//   i_load_program_write_enable  loader byte strobe (IDLE/HALTED only)
//   i_stall                      freeze fetch in RUN
//   i_branch_taken               redirect the next fetch
//   i_branch_target              redirect byte address (low 2 bits ignored)
//   i_step                       single-step advance (debug build only)
//   o_instruction                fetched instruction
//   o_pc_value                   byte address of o_instruction
//   o_valid                      o_instruction is a new fetch this cycle
//   o_is_end                     HALT_WORD fetched, sticky
//   o_load_count                 bytes accepted by the loader
//   o_load_full                  memory completely loaded
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
   parameter int                 NB_DATA                = 32,
   parameter int                 NB_BYTE                = 8,
   parameter int                 NB_INSTRUCTION_ADDRESS = 7,
   parameter logic [NB_DATA-1:0] HALT_WORD              = 32'hFC00_0000
) (
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic                            i_pc_reset,
   input  logic                            i_start,
   input  logic [NB_BYTE-1:0]              i_load_program_byte,
   input  logic                            i_load_program_write_enable,
   input  logic                            i_stall,
   input  logic                            i_branch_taken,
   input  logic [NB_DATA-1:0]              i_branch_target,
   input  logic                            i_step,
   output logic [NB_DATA-1:0]              o_instruction,
   output logic [NB_DATA-1:0]              o_pc_value,
   output logic                            o_valid,
   output logic                            o_is_end,
   output logic [NB_INSTRUCTION_ADDRESS:0] o_load_count,
   output logic                            o_load_full
);

   localparam int NB_COUNT      = NB_INSTRUCTION_ADDRESS + 1;
   localparam int NB_WORD_INDEX = NB_INSTRUCTION_ADDRESS - 2;
   localparam int N_WORDS       = 2 ** NB_WORD_INDEX;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t                   state, state_next;
   logic [NB_DATA-1:0]       pc_p0, pc_next;
   logic [NB_DATA-1:0]       instr_p1, instr_next;
   logic [NB_DATA-1:0]       pc_p1, pc_p1_next;
   logic                     vld_p1, vld_next;
   logic                     is_end_p1, is_end_next;
   logic [NB_COUNT-1:0]      load_count, load_count_next;
   logic [3*NB_BYTE-1:0]     load_buffer, load_buffer_next;
   logic                     mem_we;
   logic [NB_WORD_INDEX-1:0] mem_waddr;
   logic [NB_DATA-1:0]       mem_wdata;
   logic [NB_DATA-1:0]       fetch_word;
   logic                     fetch_en;
   logic                     load_accept;
   logic [NB_DATA-1:0]       imem [N_WORDS];

`ifdef IF_DEBUG_STEP_EN
   assign fetch_en = !i_stall && i_step;
   logic unused_inputs;
   assign unused_inputs = &{1'b0, i_branch_target[1:0]};
`else
   assign fetch_en = !i_stall;
   logic unused_inputs;
   assign unused_inputs = &{1'b0, i_branch_target[1:0], i_step};
`endif

   // PC bits above the memory size are ignored, so the index wraps
   assign fetch_word = imem[pc_p0[NB_INSTRUCTION_ADDRESS-1:2]];

   // the loader is closed while running and once every byte slot is used
   assign load_accept = (state != ST_RUN) && i_load_program_write_enable &&
                        !load_count[NB_INSTRUCTION_ADDRESS];

   always_comb begin
      state_next       = state;
      pc_next          = pc_p0;
      instr_next       = instr_p1;
      pc_p1_next       = pc_p1;
      vld_next         = 1'b0;
      is_end_next      = is_end_p1;
      load_count_next  = load_count;
      load_buffer_next = load_buffer;
      mem_we           = 1'b0;
      mem_waddr        = load_count[NB_INSTRUCTION_ADDRESS-1:2];
      mem_wdata        = {load_buffer, i_load_program_byte};

      if (i_pc_reset) begin
         state_next       = ST_IDLE;
         pc_next          = '0;
         instr_next       = '0;
         pc_p1_next       = '0;
         is_end_next      = 1'b0;
         load_count_next  = '0;
         load_buffer_next = '0;
      end else begin
         if (load_accept) begin
            load_buffer_next = {load_buffer[2*NB_BYTE-1:0], i_load_program_byte};
            load_count_next  = load_count + NB_COUNT'(1);
            // the 4th byte of a word completes it; partial words never land
            mem_we           = (load_count[1:0] == 2'b11);
         end

         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state_next = ST_RUN;
                  pc_next    = '0;
               end
            end
            ST_RUN: begin
               if (fetch_en) begin
                  instr_next = fetch_word;
                  pc_p1_next = pc_p0;
                  vld_next   = 1'b1;
                  if (fetch_word == HALT_WORD) begin
                     // halt wins over a branch; PC stays on the halt word
                     is_end_next = 1'b1;
                     state_next  = ST_HALTED;
                  end else if (i_branch_taken) begin
                     pc_next = {i_branch_target[NB_DATA-1:2], 2'b00};
                  end else begin
                     pc_next = pc_p0 + NB_DATA'(4);
                  end
               end
            end
            ST_HALTED: begin
               state_next = ST_HALTED;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   // ---- p0 (fetch PC, loader) -> p1 (registered fetch result) ----
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state       <= ST_IDLE;
         pc_p0       <= '0;
         instr_p1    <= '0;
         pc_p1       <= '0;
         vld_p1      <= 1'b0;
         is_end_p1   <= 1'b0;
         load_count  <= '0;
         load_buffer <= '0;
      end else begin
         state       <= state_next;
         pc_p0       <= pc_next;
         instr_p1    <= instr_next;
         pc_p1       <= pc_p1_next;
         vld_p1      <= vld_next;
         is_end_p1   <= is_end_next;
         load_count  <= load_count_next;
         load_buffer <= load_buffer_next;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < N_WORDS; i++) begin
            imem[i] <= '0;
         end
      end else if (mem_we) begin
         imem[mem_waddr] <= mem_wdata;
      end
   end

   assign o_instruction = instr_p1;
   assign o_pc_value    = pc_p1;
   assign o_valid       = vld_p1;
   assign o_is_end      = is_end_p1;
   assign o_load_count  = load_count;
   assign o_load_full   = load_count[NB_INSTRUCTION_ADDRESS];

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Testbench for instruction_fetch_stage: directed loader/halt sequences,
// a table of per-cycle vectors for stall/branch/wrap, and a randomized run
// compared against a behavioural model of the fetch stage.
module tb_instruction_fetch_stage;

   localparam logic [31:0] HALT_W = 32'hFC00_0000;
`ifdef IF_DEBUG_STEP_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_pc_reset = 1'b0;
   logic        i_start = 1'b0;
   logic [7:0]  i_load_program_byte = 8'd0;
   logic        i_load_program_write_enable = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_branch_taken = 1'b0;
   logic [31:0] i_branch_target = 32'd0;
   logic        i_step = 1'b1;
   logic [31:0] o_instruction;
   logic [31:0] o_pc_value;
   logic        o_valid;
   logic        o_is_end;
   logic [7:0]  o_load_count;
   logic        o_load_full;

   int n_checks = 0;
   int n_fail   = 0;

   instruction_fetch_stage dut (
      .i_clock                     (clk),
      .i_reset                     (i_reset),
      .i_pc_reset                  (i_pc_reset),
      .i_start                     (i_start),
      .i_load_program_byte         (i_load_program_byte),
      .i_load_program_write_enable (i_load_program_write_enable),
      .i_stall                     (i_stall),
      .i_branch_taken              (i_branch_taken),
      .i_branch_target             (i_branch_target),
      .i_step                      (i_step),
      .o_instruction               (o_instruction),
      .o_pc_value                  (o_pc_value),
      .o_valid                     (o_valid),
      .o_is_end                    (o_is_end),
      .o_load_count                (o_load_count),
      .o_load_full                 (o_load_full)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"}, 32'(o_valid), 32'd0);
      chk({tag, "_pc"}, o_pc_value, 32'd0);
      chk({tag, "_instr"}, o_instruction, 32'd0);
      chk({tag, "_end"}, 32'(o_is_end), 32'd0);
      chk({tag, "_count"}, 32'(o_load_count), 32'd0);
      chk({tag, "_full"}, 32'(o_load_full), 32'd0);
   endtask

   task automatic load_word(input logic [31:0] w);
      for (int k = 3; k >= 0; k--) begin
         i_load_program_write_enable = 1'b1;
         i_load_program_byte = w[8*k +: 8];
         tick();
      end
      i_load_program_write_enable = 1'b0;
   endtask

   task automatic pc_reset_pulse;
      i_pc_reset = 1'b1;
      tick();
      i_pc_reset = 1'b0;
   endtask

   function automatic logic [31:0] wv(input int i);
      return 32'h1000_0000 + 32'(i);
   endfunction

   // ---------------- table vectors ----------------
   typedef struct {
      logic        start;
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;

   vec_t vt [14];

   function automatic vec_t mkv(input logic s, input logic st, input logic b, input logic [31:0] t,
                                input logic v, input logic [31:0] p, input logic [31:0] ins);
      vec_t r;
      r.start = s; r.stall = st; r.br = b; r.tgt = t;
      r.exp_valid = v; r.exp_pc = p; r.exp_instr = ins;
      return r;
   endfunction

   // ---------------- behavioural reference model ----------------
   int          m_mode;     // 0 idle, 1 running, 2 halted
   logic [31:0] m_pc;
   int          m_count;
   logic [31:0] mem_m [32];
   logic [7:0]  bq [$];
   logic [31:0] e_instr, e_pc;
   logic        e_valid, e_end;

   task automatic model_clear(input bit wipe_mem);
      m_mode = 0; m_pc = 0; m_count = 0; bq.delete();
      e_instr = 0; e_pc = 0; e_valid = 0; e_end = 0;
      if (wipe_mem) for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
   endtask

   task automatic model_step(input logic start, input logic stall, input logic br, input logic [31:0] tgt,
                             input logic we, input logic [7:0] b, input logic step, input logic pcr);
      int old_mode;
      if (pcr) begin
         model_clear(1'b0);
         return;
      end
      old_mode = m_mode;
      e_valid = 1'b0;
      if (old_mode != 1 && we && m_count < 128) begin
         bq.push_back(b);
         m_count++;
         if (m_count % 4 == 0)
            mem_m[m_count/4 - 1] = {bq[$-3], bq[$-2], bq[$-1], bq[$]};
      end
      if (old_mode == 0 && start) begin
         m_mode = 1;
         m_pc = 0;
      end else if (old_mode == 1 && !stall && (!STEP_EN || step)) begin
         e_instr = mem_m[(m_pc / 4) % 32];
         e_pc = m_pc;
         e_valid = 1'b1;
         if (e_instr == HALT_W) begin
            e_end = 1'b1;
            m_mode = 2;
         end else if (br) begin
            m_pc = tgt - (tgt % 4);
         end else begin
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   task automatic rcycle(input logic start, input logic stall, input logic br, input logic [31:0] tgt,
                         input logic we, input logic [7:0] b, input logic step, input logic pcr);
      i_start = start; i_stall = stall; i_branch_taken = br; i_branch_target = tgt;
      i_load_program_write_enable = we; i_load_program_byte = b; i_step = step; i_pc_reset = pcr;
      model_step(start, stall, br, tgt, we, b, step, pcr);
      tick();
      chk("rnd_valid", 32'(o_valid), 32'(e_valid));
      chk("rnd_pc", o_pc_value, e_pc);
      chk("rnd_instr", o_instruction, e_instr);
      chk("rnd_end", 32'(o_is_end), 32'(e_end));
      chk("rnd_count", 32'(o_load_count), 32'(m_count));
      chk("rnd_full", 32'(o_load_full), 32'(m_count == 128));
   endtask

   initial begin
      logic [7:0] stream [$];
      int nv;

      // ---- reset state ----
      tick();
      chk_all_zero("reset");
      i_reset = 1'b0;
      tick();
      chk_all_zero("post_reset");

      // ---- async reset in the middle of a load ----
      for (int k = 0; k < 6; k++) begin
         i_load_program_write_enable = 1'b1;
         i_load_program_byte = 8'(8'h30 + k);
         tick();
      end
      i_load_program_write_enable = 1'b0;
      chk("midload_count", 32'(o_load_count), 32'd6);
      #2 i_reset = 1'b1;
      #1 chk_all_zero("midload_async");
      tick();
      i_reset = 1'b0;

      // ---- small program with halt ----
      load_word(32'h2008_0005);
      load_word(HALT_W);
      chk("prog_count", 32'(o_load_count), 32'd8);
      for (int pass = 0; pass < 2; pass++) begin
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         chk("start_latency_valid", 32'(o_valid), 32'd0);
         tick();
         chk("first_valid", 32'(o_valid), 32'd1);
         chk("first_instr", o_instruction, 32'h2008_0005);
         chk("first_pc", o_pc_value, 32'd0);
         chk("first_end", 32'(o_is_end), 32'd0);
         tick();
         chk("halt_valid", 32'(o_valid), 32'd1);
         chk("halt_instr", o_instruction, HALT_W);
         chk("halt_pc", o_pc_value, 32'd4);
         chk("halt_end", 32'(o_is_end), 32'd1);
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         chk("halted_valid", 32'(o_valid), 32'd0);
         chk("halted_pc", o_pc_value, 32'd4);
         chk("halted_instr", o_instruction, HALT_W);
         chk("halted_end", 32'(o_is_end), 32'd1);
         if (pass == 0) begin
            i_load_program_write_enable = 1'b1;
            i_load_program_byte = 8'h11;
            tick();
            i_load_program_write_enable = 1'b0;
            chk("halted_load_count", 32'(o_load_count), 32'd9);
         end
         pc_reset_pulse();
         chk_all_zero("pc_reset");
      end

      // ---- full load plus dropped extra bytes ----
      for (int w = 0; w < 31; w++) load_word(wv(w));
      chk("almost_full_count", 32'(o_load_count), 32'd124);
      chk("almost_full_flag", 32'(o_load_full), 32'd0);
      load_word(wv(31));
      chk("full_count", 32'(o_load_count), 32'd128);
      chk("full_flag", 32'(o_load_full), 32'd1);
      for (int k = 0; k < 3; k++) begin
         i_load_program_write_enable = 1'b1;
         i_load_program_byte = 8'hAA;
         tick();
      end
      i_load_program_write_enable = 1'b0;
      chk("extra_count", 32'(o_load_count), 32'd128);
      chk("extra_full", 32'(o_load_full), 32'd1);

      // ---- table: start, stall with ignored branch, branch, masking, wrap ----
      vt[0]  = mkv(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0);
      vt[1]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        wv(0));
      vt[2]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        wv(1));
      vt[3]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h4,        wv(1));
      vt[4]  = mkv(1'b0, 1'b1, 1'b1, 32'h60,       1'b0, 32'h4,        wv(1));
      vt[5]  = mkv(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h4,        wv(1));
      vt[6]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        wv(2));
      vt[7]  = mkv(1'b0, 1'b0, 1'b1, 32'h40,       1'b1, 32'hC,        wv(3));
      vt[8]  = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       wv(16));
      vt[9]  = mkv(1'b0, 1'b0, 1'b1, 32'h7F,       1'b1, 32'h44,       wv(17));
      vt[10] = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h7C,       wv(31));
      vt[11] = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h80,       wv(0));
      vt[12] = mkv(1'b0, 1'b0, 1'b1, 32'hFFFFFF04, 1'b1, 32'h84,       wv(1));
      vt[13] = mkv(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFFFF04, wv(1));
      for (int r = 0; r < 14; r++) begin
         i_start = vt[r].start;
         i_stall = vt[r].stall;
         i_branch_taken = vt[r].br;
         i_branch_target = vt[r].tgt;
         tick();
         chk($sformatf("vec%0d_valid", r), 32'(o_valid), 32'(vt[r].exp_valid));
         chk($sformatf("vec%0d_pc", r), o_pc_value, vt[r].exp_pc);
         chk($sformatf("vec%0d_instr", r), o_instruction, vt[r].exp_instr);
         chk($sformatf("vec%0d_end", r), 32'(o_is_end), 32'd0);
      end
      i_start = 1'b0; i_stall = 1'b0; i_branch_taken = 1'b0; i_branch_target = 32'd0;

      // ---- async reset while running; memory must read back zero ----
      #2 i_reset = 1'b1;
      #1 chk_all_zero("midrun_async");
      tick();
      i_reset = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      tick();
      chk("zeromem_valid", 32'(o_valid), 32'd1);
      chk("zeromem_pc", o_pc_value, 32'd0);
      chk("zeromem_instr", o_instruction, 32'd0);
      pc_reset_pulse();

`ifdef IF_DEBUG_STEP_EN
      // ---- single-step: three pulses four cycles apart ----
      i_step = 1'b0;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      nv = 0;
      for (int c = 0; c < 12; c++) begin
         i_step = (c % 4 == 0);
         tick();
         if (o_valid) begin
            chk("step_pc", o_pc_value, 32'(nv * 4));
            nv++;
         end
      end
      chk("step_fetches", 32'(nv), 32'd3);
      i_step = 1'b1;
      pc_reset_pulse();
`endif

      // ---- randomized run against the model ----
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      model_clear(1'b1);
      for (int it = 0; it < 4; it++) begin
         stream.delete();
         nv = $urandom_range(20, 34);
         for (int w = 0; w < nv; w++) begin
            logic [31:0] word;
            word = ($urandom_range(0, 9) == 0) ? HALT_W : 32'($urandom);
            for (int k = 3; k >= 0; k--) stream.push_back(word[8*k +: 8]);
         end
         for (int k = $urandom_range(0, 3); k > 0; k--) stream.push_back(8'($urandom));
         while (stream.size() > 0) begin
            logic we;
            logic [7:0] b;
            we = ($urandom_range(0, 5) != 0);
            b = we ? stream[0] : 8'($urandom);
            if (we) void'(stream.pop_front());
            rcycle(1'b0, 1'($urandom), 1'($urandom), 32'($urandom), we, b, 1'($urandom), 1'b0);
         end
         rcycle(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b0);
         for (int c = 0; c < 60; c++) begin
            rcycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   32'($urandom), $urandom_range(0, 2) == 0, 8'($urandom),
                   $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
         end
         rcycle(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 1'b1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
